// File: rtl/id1_inst_queue.sv
// ---------------------------------------------------------------------------
// id1_inst_queue
//   Dual-bank (a/b) instruction queue between IF and ID2. Up to two
//   instructions per cycle are stored in program order, interleaved a,b,a,b
//   across the two banks. The raw bank arrays and the one-hot read tails are
//   exported so the downstream read mux can pick the oldest two entries.
//
// Optional feature macro: IBUF_STALL_CNT_EN
//   When this macro is defined, the stall_cnt output and its counter are added.
//
// Ports
//   clk, rst            clock (rising edge) / asynchronous active-high reset
//   flush               synchronous flush; it overrides a push or pop in the same cycle
//   in_valid[1:0]       [0] older instruction valid, [1] younger instruction valid
//   in0_*/in1_*         pc, instruction word, {brtype,pc_pre}, exception code
//   in_ready            room for two instructions (from the registered cnt)
//   pop[1:0]            number of instructions ID2 consumes (3 is treated as 2)
//   out_valid[1:0]      oldest / second-oldest instruction present
//   old_is_b            the oldest instruction sits in bank b
//   a_tail, b_tail      one-hot read pointers
//   a_*_Buffer, b_*_Buffer  registered bank storage
//   cnt                 occupancy
//   stall_cnt           (optional) cycles where a push was refused for lack of space
// ---------------------------------------------------------------------------
module id1_inst_queue #(
   parameter int NUM = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [1:0]                  in_valid,
   input  logic [31:0]                 in0_pc,
   input  logic [31:0]                 in1_pc,
   input  logic [31:0]                 in0_ir,
   input  logic [31:0]                 in1_ir,
   input  logic [33:0]                 in0_bp,
   input  logic [33:0]                 in1_bp,
   input  logic [7:0]                  in0_ecode,
   input  logic [7:0]                  in1_ecode,
   output logic                        in_ready,
   input  logic [1:0]                  pop,
   output logic [1:0]                  out_valid,
   output logic                        old_is_b,
   output logic [NUM-1:0]              a_tail,
   output logic [NUM-1:0]              b_tail,
   output logic [31:0]                 a_PC_Buffer [NUM],
   output logic [31:0]                 a_IR_Buffer [NUM],
   output logic [33:0]                 a_brtype_pcpre_Buffer [NUM],
   output logic [7:0]                  a_ecode_Buffer [NUM],
   output logic [31:0]                 b_PC_Buffer [NUM],
   output logic [31:0]                 b_IR_Buffer [NUM],
   output logic [33:0]                 b_brtype_pcpre_Buffer [NUM],
   output logic [7:0]                  b_ecode_Buffer [NUM],
   output logic [$clog2(2*NUM):0]      cnt
`ifdef IBUF_STALL_CNT_EN
   ,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam int CW = $clog2(2*NUM) + 1;
   localparam logic [CW-1:0] READY_LIM = CW'(2*NUM - 2);
   localparam logic [NUM-1:0] PTR_INIT = NUM'(1);

   logic [NUM-1:0] a_head, b_head;
   logic           wr_ph, rd_ph;

   logic           push_both, push_one;
   logic           a_we, b_we;
   logic [1:0]     push_n, pop_req, pop_n;
   logic [31:0]    a_pc_d, b_pc_d, a_ir_d, b_ir_d;
   logic [33:0]    a_bp_d, b_bp_d;
   logic [7:0]     a_ec_d, b_ec_d;

   assign in_ready  = (cnt <= READY_LIM);
   assign out_valid = {(cnt >= CW'(2)), (cnt >= CW'(1))};
   assign old_is_b  = rd_ph;

   // in_valid=2'b10 (younger without older) is not a legal pair and is ignored.
   assign push_both = in_ready && (in_valid == 2'b11);
   assign push_one  = in_ready && (in_valid == 2'b01);
   assign push_n    = push_both ? 2'd2 : (push_one ? 2'd1 : 2'd0);

   // in0 lands in bank wr_ph, in1 in the other bank.
   assign a_we = push_both || (push_one && !wr_ph);
   assign b_we = push_both || (push_one &&  wr_ph);

   always_comb begin
      a_pc_d = wr_ph ? in1_pc    : in0_pc;
      a_ir_d = wr_ph ? in1_ir    : in0_ir;
      a_bp_d = wr_ph ? in1_bp    : in0_bp;
      a_ec_d = wr_ph ? in1_ecode : in0_ecode;
      b_pc_d = wr_ph ? in0_pc    : in1_pc;
      b_ir_d = wr_ph ? in0_ir    : in1_ir;
      b_bp_d = wr_ph ? in0_bp    : in1_bp;
      b_ec_d = wr_ph ? in0_ecode : in1_ecode;
   end

   // The effective pop is clamped to the current occupancy; pop=3 behaves as 2.
   always_comb begin
      pop_req = (pop == 2'd0) ? 2'd0 : ((pop == 2'd1) ? 2'd1 : 2'd2);
      pop_n   = pop_req;
      if (cnt == CW'(0))
         pop_n = 2'd0;
      else if ((cnt == CW'(1)) && (pop_req == 2'd2))
         pop_n = 2'd1;
   end

   function automatic logic [NUM-1:0] rotl(input logic [NUM-1:0] x);
      return {x[NUM-2:0], x[NUM-1]};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_head <= PTR_INIT;
         b_head <= PTR_INIT;
         a_tail <= PTR_INIT;
         b_tail <= PTR_INIT;
         wr_ph  <= 1'b0;
         rd_ph  <= 1'b0;
         cnt    <= '0;
      end else if (flush) begin
         a_head <= PTR_INIT;
         b_head <= PTR_INIT;
         a_tail <= PTR_INIT;
         b_tail <= PTR_INIT;
         wr_ph  <= 1'b0;
         rd_ph  <= 1'b0;
         cnt    <= '0;
      end else begin
         if (a_we) a_head <= rotl(a_head);
         if (b_we) b_head <= rotl(b_head);
         if (push_one) wr_ph <= ~wr_ph;
         if (pop_n == 2'd2) begin
            a_tail <= rotl(a_tail);
            b_tail <= rotl(b_tail);
         end else if (pop_n == 2'd1) begin
            if (rd_ph) b_tail <= rotl(b_tail);
            else       a_tail <= rotl(a_tail);
            rd_ph <= ~rd_ph;
         end
         cnt <= cnt + CW'(push_n) - CW'(pop_n);
      end
   end

   // Storage is written only on an accepted push; pop and flush leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM; i++) begin
            a_PC_Buffer[i]           <= '0;
            a_IR_Buffer[i]           <= '0;
            a_brtype_pcpre_Buffer[i] <= '0;
            a_ecode_Buffer[i]        <= '0;
            b_PC_Buffer[i]           <= '0;
            b_IR_Buffer[i]           <= '0;
            b_brtype_pcpre_Buffer[i] <= '0;
            b_ecode_Buffer[i]        <= '0;
         end
      end else if (!flush) begin
         for (int i = 0; i < NUM; i++) begin
            if (a_we && a_head[i]) begin
               a_PC_Buffer[i]           <= a_pc_d;
               a_IR_Buffer[i]           <= a_ir_d;
               a_brtype_pcpre_Buffer[i] <= a_bp_d;
               a_ecode_Buffer[i]        <= a_ec_d;
            end
            if (b_we && b_head[i]) begin
               b_PC_Buffer[i]           <= b_pc_d;
               b_IR_Buffer[i]           <= b_ir_d;
               b_brtype_pcpre_Buffer[i] <= b_bp_d;
               b_ecode_Buffer[i]        <= b_ec_d;
            end
         end
      end
   end

`ifdef IBUF_STALL_CNT_EN
   // Saturating count of refused push cycles; flush does not clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if ((in_valid != 2'b00) && !in_ready && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_id1_inst_queue.sv
module tb_id1_inst_queue;

   localparam int NUM = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  in_valid;
   logic [31:0] in0_pc, in1_pc, in0_ir, in1_ir;
   logic [33:0] in0_bp, in1_bp;
   logic [7:0]  in0_ecode, in1_ecode;
   logic        in_ready;
   logic [1:0]  pop;
   logic [1:0]  out_valid;
   logic        old_is_b;
   logic [NUM-1:0] a_tail, b_tail;
   logic [31:0] a_pc [NUM];
   logic [31:0] a_ir [NUM];
   logic [33:0] a_bp [NUM];
   logic [7:0]  a_ec [NUM];
   logic [31:0] b_pc [NUM];
   logic [31:0] b_ir [NUM];
   logic [33:0] b_bp [NUM];
   logic [7:0]  b_ec [NUM];
   logic [5:0]  cnt;
`ifdef IBUF_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_base;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   id1_inst_queue #(.NUM(NUM)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
      .in0_pc(in0_pc), .in1_pc(in1_pc), .in0_ir(in0_ir), .in1_ir(in1_ir),
      .in0_bp(in0_bp), .in1_bp(in1_bp), .in0_ecode(in0_ecode), .in1_ecode(in1_ecode),
      .in_ready(in_ready), .pop(pop), .out_valid(out_valid), .old_is_b(old_is_b),
      .a_tail(a_tail), .b_tail(b_tail),
      .a_PC_Buffer(a_pc), .a_IR_Buffer(a_ir), .a_brtype_pcpre_Buffer(a_bp), .a_ecode_Buffer(a_ec),
      .b_PC_Buffer(b_pc), .b_IR_Buffer(b_ir), .b_brtype_pcpre_Buffer(b_bp), .b_ecode_Buffer(b_ec),
`ifdef IBUF_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .cnt(cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] pp, input logic fl);
      in_valid  = v;
      in0_pc    = p0;        in1_pc    = p1;
      in0_ir    = ~p0;       in1_ir    = ~p1;
      in0_bp    = {2'b01, p0}; in1_bp  = {2'b10, p1};
      in0_ecode = p0[7:0];   in1_ecode = p1[7:0];
      pop       = pp;
      flush     = fl;
      @(posedge clk);
      #1;
      in_valid = 2'b00;
      pop      = 2'd0;
      flush    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 2'b00; pop = 2'd0;
      in0_pc = '0; in1_pc = '0; in0_ir = '0; in1_ir = '0;
      in0_bp = '0; in1_bp = '0; in0_ecode = '0; in1_ecode = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_a_tail", a_tail, 64'h0001);
      check("rst_b_tail", b_tail, 64'h0001);
      check("rst_cnt", cnt, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_old_is_b", old_is_b, 0);

      // Double push
      cyc(2'b11, 32'h1c000000, 32'h1c000004, 0, 0);
      check("dbl_out_valid", out_valid, 2'b11);
      check("dbl_old_is_b", old_is_b, 0);
      check("dbl_cnt", cnt, 2);
      check("dbl_a_pc0", a_pc[0], 32'h1c000000);
      check("dbl_b_pc0", b_pc[0], 32'h1c000004);
      check("dbl_a_ir0", a_ir[0], 32'he3ffffff);
      check("dbl_a_bp0", a_bp[0], 34'h1_1c000000);
      check("dbl_b_ec0", b_ec[0], 8'h04);

      // Single pushes alternate banks while one pop per cycle drains
      cyc(2'b00, 0, 0, 0, 1);
      check("fl1_cnt", cnt, 0);
      cyc(2'b01, 32'h100, 32'hdead, 0, 0);
      check("s1_cnt", cnt, 1);
      check("s1_old_is_b", old_is_b, 0);
      check("s1_a_pc0", a_pc[0], 32'h100);
      cyc(2'b01, 32'h104, 32'hdead, 1, 0);
      check("s2_cnt", cnt, 1);
      check("s2_old_is_b", old_is_b, 1);
      check("s2_b_pc0", b_pc[0], 32'h104);
      check("s2_a_tail", a_tail, 64'h0002);
      cyc(2'b01, 32'h108, 32'hdead, 1, 0);
      check("s3_cnt", cnt, 1);
      check("s3_old_is_b", old_is_b, 0);
      check("s3_a_pc1", a_pc[1], 32'h108);
      check("s3_b_tail", b_tail, 64'h0002);

      // Fill to capacity
      cyc(2'b00, 0, 0, 0, 1);
      for (int k = 0; k < 16; k++) begin
         cyc(2'b11, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 0, 0);
         if (k == 14) begin
            check("fill30_cnt", cnt, 30);
            check("fill30_in_ready", in_ready, 1);
         end
      end
      check("full_cnt", cnt, 32);
      check("full_in_ready", in_ready, 0);
      check("full_a_pc15", a_pc[15], 32'h1078);
`ifdef IBUF_STALL_CNT_EN
      stall_base = stall_cnt;
      for (int k = 0; k < 10; k++) cyc(2'b11, 32'h9100, 32'h9104, 0, 0);
      check("stall_delta", stall_cnt - stall_base, 10);
`endif
      cyc(2'b11, 32'h9000, 32'h9004, 0, 0);
      check("full_ign_cnt", cnt, 32);
      check("full_ign_a_pc0", a_pc[0], 32'h1000);
      cyc(2'b11, 32'h9000, 32'h9004, 2, 0);
      check("fullpop_cnt", cnt, 30);
      check("fullpop_a_tail", a_tail, 64'h0002);
      check("fullpop_in_ready", in_ready, 1);
      for (int k = 0; k < 14; k++) cyc(2'b00, 0, 0, 2, 0);
      check("drain_a_tail", a_tail, 64'h8000);
      check("drain_b_tail", b_tail, 64'h8000);
      check("drain_cnt", cnt, 2);
      check("drain_b_pc15", b_pc[15], 32'h107c);
      cyc(2'b00, 0, 0, 2, 0);
      check("wrap_a_tail", a_tail, 64'h0001);
      check("wrap_b_tail", b_tail, 64'h0001);
      check("wrap_cnt", cnt, 0);
      check("wrap_out_valid", out_valid, 0);

      // pop=3 clamped to occupancy 1; push into empty queue is not popped
      cyc(2'b01, 32'h500, 0, 0, 0);
      cyc(2'b00, 0, 0, 3, 0);
      check("pop3_cnt", cnt, 0);
      check("pop3_a_tail", a_tail, 64'h0002);
      check("pop3_old_is_b", old_is_b, 1);
      cyc(2'b01, 32'h600, 0, 1, 0);
      check("emptypush_cnt", cnt, 1);
      check("emptypush_out_valid", out_valid, 2'b01);
      check("emptypush_b_pc0", b_pc[0], 32'h600);
      cyc(2'b10, 32'h700, 32'h704, 0, 0);
      check("v10_cnt", cnt, 1);

      // Flush overrides push and pop
      cyc(2'b00, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) cyc(2'b11, 32'h2000 + 32'(8*k), 32'h2004 + 32'(8*k), 0, 0);
      cyc(2'b00, 0, 0, 1, 0);
      check("pre_fl_cnt", cnt, 5);
      cyc(2'b11, 32'h7000, 32'h7004, 2, 1);
      check("fl_cnt", cnt, 0);
      check("fl_a_tail", a_tail, 64'h0001);
      check("fl_b_tail", b_tail, 64'h0001);
      check("fl_out_valid", out_valid, 0);
      check("fl_old_is_b", old_is_b, 0);
      check("fl_a_pc3_kept", a_pc[3], 32'h1018);
      cyc(2'b11, 32'h7100, 32'h7104, 0, 0);
      check("postfl_a_pc0", a_pc[0], 32'h7100);
      check("postfl_cnt", cnt, 2);

      // Asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      check("arst_cnt", cnt, 0);
      check("arst_a_tail", a_tail, 64'h0001);
      check("arst_out_valid", out_valid, 0);
      check("arst_a_pc0", a_pc[0], 0);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
